// File: rtl/sudoku_grid_checker_if.sv
// Cell stream handshake between the 4x4 digit decoder (master) and the grid checker (slave).
interface sudoku_grid_checker_if;
   logic       in_valid;
   logic [3:0] in_onehot;
   logic       in_ready;

   modport master (output in_valid, output in_onehot, input in_ready);
   modport slave  (input in_valid, input in_onehot, output in_ready);
endinterface

// File: rtl/sudoku_grid_checker.sv
// 4x4 sudoku grid checker: accumulates row/column/box digit masks over a 16-cell stream.
// Optional macro SUDOKU_CHECKER_EARLY_ABORT_EN reports as soon as the first conflict is seen.
module sudoku_grid_checker #(
   parameter int CELLS = 16,
   parameter int IDXW  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   sudoku_grid_checker_if.slave  bus,
   output logic                  busy,
   output logic                  done,
   output logic                  grid_ok,
   output logic                  grid_full,
   output logic [IDXW-1:0]       conflict_idx
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   state_t          state_r, state_nx;
   logic [IDXW-1:0] cnt_r;
   logic [3:0]      row_mask_r [4];
   logic [3:0]      col_mask_r [4];
   logic [3:0]      box_mask_r [4];
   logic            conflict_r;
   logic            empty_r;

   logic [1:0]      row_s, col_s, box_s;
   logic            xfer_s, empty_s, malformed_s, clash_s, last_s, first_clash_s;
   logic            clear_s, enter_report_s;

   function automatic logic multi_hot(input logic [3:0] v);
      return (v & (v - 4'd1)) != 4'd0;
   endfunction

   assign row_s          = cnt_r[3:2];
   assign col_s          = cnt_r[1:0];
   assign box_s          = {row_s[1], col_s[1]};
   // A cell presented together with start is dropped: restart has priority.
   assign xfer_s         = (state_r == ST_ACCEPT) && bus.in_valid && !start;
   assign empty_s        = (bus.in_onehot == 4'b0000);
   assign malformed_s    = multi_hot(bus.in_onehot);
   assign clash_s        = malformed_s ||
                           ((bus.in_onehot & (row_mask_r[row_s] | col_mask_r[col_s] |
                                              box_mask_r[box_s])) != 4'b0000);
   assign last_s         = (cnt_r == IDXW'(CELLS - 1));
   assign first_clash_s  = xfer_s && clash_s && !conflict_r;
   assign clear_s        = start && (state_r != ST_REPORT);
   assign enter_report_s = (state_r == ST_ACCEPT) && (state_nx == ST_REPORT);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nx = ST_ACCEPT;
            else       state_nx = ST_IDLE;
         end
         ST_ACCEPT: begin
            if (start)                    state_nx = ST_ACCEPT;
            else if (xfer_s && last_s)    state_nx = ST_REPORT;
`ifdef SUDOKU_CHECKER_EARLY_ABORT_EN
            else if (first_clash_s)       state_nx = ST_REPORT;
`endif
            else                          state_nx = ST_ACCEPT;
         end
         ST_REPORT: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      bus.in_ready = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state_r)
         ST_ACCEPT: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
         end
         ST_REPORT: done = 1'b1;
         default: begin
            bus.in_ready = 1'b0;
            busy         = 1'b0;
            done         = 1'b0;
         end
      endcase
   end

   // Mask accumulation, flags and result registers
   always_ff @(posedge clk) begin
      if (reset || clear_s) begin
         cnt_r        <= {IDXW{1'b0}};
         conflict_r   <= 1'b0;
         empty_r      <= 1'b0;
         conflict_idx <= {IDXW{1'b0}};
         grid_ok      <= 1'b0;
         grid_full    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            row_mask_r[i] <= 4'b0000;
            col_mask_r[i] <= 4'b0000;
            box_mask_r[i] <= 4'b0000;
         end
      end else if (xfer_s) begin
         cnt_r <= cnt_r + IDXW'(1);
         if (empty_s) begin
            empty_r <= 1'b1;
         end else if (!malformed_s) begin
            row_mask_r[row_s] <= row_mask_r[row_s] | bus.in_onehot;
            col_mask_r[col_s] <= col_mask_r[col_s] | bus.in_onehot;
            box_mask_r[box_s] <= box_mask_r[box_s] | bus.in_onehot;
         end
         if (first_clash_s) begin
            conflict_r   <= 1'b1;
            conflict_idx <= cnt_r;
         end
         // Results must already be valid in the done cycle, so fold in the current cell.
         if (enter_report_s) begin
            grid_ok   <= !(conflict_r || clash_s);
            grid_full <= !(empty_r || empty_s);
         end
      end
   end

endmodule

// File: tb/tb_sudoku_grid_checker.sv
// Directed self-checking bench for sudoku_grid_checker (default and early-abort builds).
module tb_sudoku_grid_checker;
   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       busy, done, grid_ok, grid_full;
   logic [3:0] conflict_idx;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] solved [16];

   sudoku_grid_checker_if bus ();

   sudoku_grid_checker dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus), .busy(busy), .done(done),
      .grid_ok(grid_ok), .grid_full(grid_full), .conflict_idx(conflict_idx)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Drives cells until 16 transfers, done seen, or the cycle budget runs out.
   task automatic drive_grid(input logic [3:0] g [16], input bit gapped,
                             output int n_xfer, output int n_ready, output bit done_seen);
      int cyc = 0;
      bit v, r;
      n_xfer = 0; n_ready = 0; done_seen = 1'b0;
      while (n_xfer < 16 && cyc < 100 && !done_seen) begin
         v = gapped ? (cyc % 2 == 0) : 1'b1;
         bus.in_valid  = v;
         bus.in_onehot = g[n_xfer];
         r = bus.in_ready;
         if (r) n_ready++;
         tick();
         cyc++;
         if (v && r) n_xfer++;
         done_seen = done;
      end
      bus.in_valid = 1'b0; bus.in_onehot = 4'b0000;
   endtask

   task automatic do_start();
      start = 1'b1; tick(); start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %0b want 1", busy); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL start_ready: got %0b want 1", bus.in_ready); end
      checks++; if (grid_ok !== 1'b0 || grid_full !== 1'b0 || conflict_idx !== 4'd0) begin
         errors++; $display("FAIL start_clear: ok=%0b full=%0b idx=%0d want 0/0/0", grid_ok, grid_full, conflict_idx); end
   endtask

   task automatic check_result(input string tag, input int n_xfer, input int exp_xfer, input bit done_seen,
                               input logic exp_ok, input logic exp_full, input logic [3:0] exp_idx);
      checks++; if (n_xfer !== exp_xfer) begin errors++; $display("FAIL %s xfers: got %0d want %0d", tag, n_xfer, exp_xfer); end
      checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL %s done: got %0b want 1", tag, done_seen); end
      checks++; if (grid_ok !== exp_ok) begin errors++; $display("FAIL %s grid_ok: got %0b want %0b", tag, grid_ok, exp_ok); end
      checks++; if (grid_full !== exp_full) begin errors++; $display("FAIL %s grid_full: got %0b want %0b", tag, grid_full, exp_full); end
      checks++; if (conflict_idx !== exp_idx) begin errors++; $display("FAIL %s conflict_idx: got %0d want %0d", tag, conflict_idx, exp_idx); end
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL %s pulse: done=%0b busy=%0b want 0/0", tag, done, busy); end
      checks++; if (grid_ok !== exp_ok || conflict_idx !== exp_idx) begin
         errors++; $display("FAIL %s hold: ok=%0b idx=%0d want %0b/%0d", tag, grid_ok, conflict_idx, exp_ok, exp_idx); end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_onehot = 4'b0000;
      tick(); tick();
      reset = 1'b0;
      checks++; if ({bus.in_ready, busy, done, grid_ok, grid_full, conflict_idx} !== 9'd0) begin
         errors++; $display("FAIL reset_state: got %b want 000000000", {bus.in_ready, busy, done, grid_ok, grid_full, conflict_idx}); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy=%0b want 0", busy); end
   endtask

   task automatic test_solved();
      int nx, nr; bit ds;
      do_start();
      drive_grid(solved, 1'b0, nx, nr, ds);
      checks++; if (nr !== 16) begin errors++; $display("FAIL solved_ready_cycles: got %0d want 16", nr); end
      // Start during REPORT is ignored; in_valid in IDLE has no effect.
      start = 1'b1; bus.in_valid = 1'b1; bus.in_onehot = 4'b0001;
      check_result("solved", nx, 16, ds, 1'b1, 1'b1, 4'd0);
      start = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (busy !== 1'b0 || grid_ok !== 1'b1 || grid_full !== 1'b1) begin
         errors++; $display("FAIL idle_ignore: busy=%0b ok=%0b full=%0b want 0/1/1", busy, grid_ok, grid_full); end
   endtask

   task automatic test_conflict();
      logic [3:0] g [16];
      int nx, nr; bit ds;
      g = solved; g[5] = 4'b0010;
      do_start();
      drive_grid(g, 1'b0, nx, nr, ds);
`ifdef SUDOKU_CHECKER_EARLY_ABORT_EN
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %0b want 0", bus.in_ready); end
      check_result("conflict", nx, 6, ds, 1'b0, 1'b1, 4'd5);
`else
      check_result("conflict", nx, 16, ds, 1'b0, 1'b1, 4'd5);
`endif
   endtask

   task automatic test_empty();
      logic [3:0] g [16];
      int nx, nr; bit ds;
      g = solved; g[10] = 4'b0000;
      do_start();
      drive_grid(g, 1'b0, nx, nr, ds);
      check_result("empty", nx, 16, ds, 1'b1, 1'b0, 4'd0);
   endtask

   task automatic test_malformed();
      logic [3:0] g [16];
      int nx, nr; bit ds;
      g = solved; g[0] = 4'b0011;
      do_start();
      drive_grid(g, 1'b0, nx, nr, ds);
`ifdef SUDOKU_CHECKER_EARLY_ABORT_EN
      check_result("malformed", nx, 1, ds, 1'b0, 1'b1, 4'd0);
`else
      check_result("malformed", nx, 16, ds, 1'b0, 1'b1, 4'd0);
`endif
   endtask

   task automatic test_gapped();
      int nx, nr; bit ds;
      do_start();
      drive_grid(solved, 1'b1, nx, nr, ds);
      checks++; if (nr !== 31) begin errors++; $display("FAIL gapped_ready_cycles: got %0d want 31", nr); end
      check_result("gapped", nx, 16, ds, 1'b1, 1'b1, 4'd0);
   endtask

   task automatic test_restart();
      int nx, nr; bit ds;
      do_start();
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1; bus.in_onehot = solved[i]; tick();
      end
      // This cell arrives with start and must be discarded.
      start = 1'b1; bus.in_onehot = 4'b1000; tick(); start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL restart_busy: got %0b want 1", busy); end
      drive_grid(solved, 1'b0, nx, nr, ds);
      check_result("restart", nx, 16, ds, 1'b1, 1'b1, 4'd0);
   endtask

   task automatic test_reset_mid();
      int nx, nr; bit ds;
      bit saw_done = 1'b0;
      do_start();
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'b1; bus.in_onehot = solved[i]; tick();
      end
      reset = 1'b1; tick(); reset = 1'b0; bus.in_valid = 1'b0;
      checks++; if ({bus.in_ready, busy, done, grid_ok, grid_full, conflict_idx} !== 9'd0) begin
         errors++; $display("FAIL midreset_state: got %b want 000000000", {bus.in_ready, busy, done, grid_ok, grid_full, conflict_idx}); end
      for (int i = 0; i < 8; i++) begin
         tick(); if (done) saw_done = 1'b1;
      end
      checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %0b want 0", saw_done); end
      do_start();
      drive_grid(solved, 1'b0, nx, nr, ds);
      check_result("after_reset", nx, 16, ds, 1'b1, 1'b1, 4'd0);
   endtask

   initial begin
      logic [3:0] digits [16];
      digits = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd4, 4'd1, 4'd2,
                 4'd2, 4'd1, 4'd4, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1};
      for (int i = 0; i < 16; i++) solved[i] = 4'b0001 << (digits[i] - 4'd1);
      test_reset();
      test_solved();
      test_conflict();
      test_empty();
      test_malformed();
      test_gapped();
      test_restart();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
